// File: rtl/ysyx_lsu_pkg.sv
// Shared types and constants for the load/store unit.
package ysyx_lsu_pkg;

    localparam int unsigned BIT_W  = 32;
    localparam int unsigned STRB_W = BIT_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_D  = 3'd2,
        ST_WR_AW = 3'd3,
        ST_WR_B  = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_e;

    // inst[14:12] encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Halfword accesses need addr[0]==0, word accesses need addr[1:0]==0.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
        return ((func3[1:0] == 2'b01) && addr_lo[0]) ||
               ((func3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_lsu_if.sv
// AXI4-Lite data-side bus between the LSU (master) and memory (slave).
interface ysyx_lsu_if;
    import ysyx_lsu_pkg::*;

    logic [BIT_W-1:0]  araddr;
    logic              arvalid;
    logic              arready;
    logic [BIT_W-1:0]  rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [BIT_W-1:0]  awaddr;
    logic              awvalid;
    logic              awready;
    logic [BIT_W-1:0]  wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );

endinterface

// File: rtl/ysyx_lsu_align.sv
// Byte-lane alignment: load shift/extend and store shift/strobe generation.
module ysyx_lsu_align
    import ysyx_lsu_pkg::*;
(
    input  logic [1:0]        ld_addr_lo,
    input  logic [2:0]        ld_func3,
    input  logic [BIT_W-1:0]  ld_rdata,
    output logic [BIT_W-1:0]  ld_data_c,
    input  logic [1:0]        st_addr_lo,
    input  logic [2:0]        st_func3,
    input  logic [BIT_W-1:0]  st_wdata,
    output logic [BIT_W-1:0]  st_wdata_c,
    output logic [STRB_W-1:0] st_wstrb_c
);

    logic [BIT_W-1:0] ld_shifted;

    // Load: move the addressed lane down to bit 0, then extend by access type
    always_comb begin
        ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};
        case (ld_func3)
            F3_LB:   ld_data_c = {{(BIT_W-8){ld_shifted[7]}}, ld_shifted[7:0]};
            F3_LBU:  ld_data_c = {{(BIT_W-8){1'b0}}, ld_shifted[7:0]};
            F3_LH:   ld_data_c = {{(BIT_W-16){ld_shifted[15]}}, ld_shifted[15:0]};
            F3_LHU:  ld_data_c = {{(BIT_W-16){1'b0}}, ld_shifted[15:0]};
            F3_LW:   ld_data_c = ld_shifted;
            default: ld_data_c = ld_shifted;
        endcase
    end

    // Store: move right-justified data up to its lane and enable matching bytes
    always_comb begin
        st_wdata_c = st_wdata << {st_addr_lo, 3'b000};
        case (st_func3)
            F3_SB:   st_wstrb_c = STRB_W'(4'b0001) << st_addr_lo;
            F3_SH:   st_wstrb_c = STRB_W'(4'b0011) << st_addr_lo;
            F3_SW:   st_wstrb_c = STRB_W'(4'b1111);
            default: st_wstrb_c = STRB_W'(4'b1111);
        endcase
    end

endmodule

// File: rtl/ysyx_lsu.sv
// Load/store unit: one EXU request at a time onto an AXI4-Lite data bus.
module ysyx_lsu
    import ysyx_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_avalid,
    input  logic              lsu_ren,
    input  logic              lsu_wen,
    input  logic [BIT_W-1:0]  lsu_addr,
    input  logic [BIT_W-1:0]  lsu_wdata,
    input  logic [2:0]        lsu_func3,
    output logic [BIT_W-1:0]  lsu_rdata_o,
    output logic              lsu_rvalid_o,
    output logic              lsu_wready_o,
    output logic              lsu_fault_o,
    ysyx_lsu_if.master        bus
);

    lsu_state_e        state_q, state_d;
    logic [BIT_W-1:0]  addr_q, addr_d;
    logic [2:0]        func3_q, func3_d;
    logic [BIT_W-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              rvalid_q, rvalid_d;
    logic              wready_q, wready_d;
    logic              fault_q, fault_d;
    logic [BIT_W-1:0]  rdata_q, rdata_d;

    logic [BIT_W-1:0]  ld_data_c;
    logic [BIT_W-1:0]  st_wdata_c;
    logic [STRB_W-1:0] st_wstrb_c;
    logic              aw_hs_c, w_hs_c;

    ysyx_lsu_align u_align (
        .ld_addr_lo (addr_q[1:0]),
        .ld_func3   (func3_q),
        .ld_rdata   (bus.rdata),
        .ld_data_c  (ld_data_c),
        .st_addr_lo (lsu_addr[1:0]),
        .st_func3   (lsu_func3),
        .st_wdata   (lsu_wdata),
        .st_wdata_c (st_wdata_c),
        .st_wstrb_c (st_wstrb_c)
    );

    assign aw_hs_c = awvalid_q & bus.awready;
    assign w_hs_c  = wvalid_q & bus.wready;

    // Next-state and next-output logic; outputs are set on entry to the state that owns them
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        func3_d   = func3_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        wready_d  = 1'b0;
        fault_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (lsu_avalid && (lsu_ren || lsu_wen)) begin
                    addr_d  = lsu_addr;
                    func3_d = lsu_func3;
                    wdata_d = st_wdata_c;
                    wstrb_d = st_wstrb_c;
                    if (is_misaligned(lsu_func3, lsu_addr[1:0])) begin
                        state_d  = ST_RESP;
                        fault_d  = 1'b1;
                        rvalid_d = lsu_ren;
                        wready_d = ~lsu_ren;
                    end else if (lsu_ren) begin
                        state_d   = ST_RD_A;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = ST_WR_AW;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end
            end
            ST_RD_A: begin
                if (arvalid_q && bus.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_D;
                end
            end
            ST_RD_D: begin
                if (bus.rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = ld_data_c;
                    fault_d  = (bus.rresp != AXI_RESP_OKAY);
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_WR_AW: begin
                if (aw_hs_c) awvalid_d = 1'b0;
                if (w_hs_c)  wvalid_d  = 1'b0;
                aw_done_d = aw_done_q | aw_hs_c;
                w_done_d  = w_done_q | w_hs_c;
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (bus.bvalid) begin
                    bready_d = 1'b0;
                    fault_d  = (bus.bresp != AXI_RESP_OKAY);
                    wready_d = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            func3_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            wready_q  <= 1'b0;
            fault_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            func3_q   <= func3_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= rvalid_d;
            wready_q  <= wready_d;
            fault_q   <= fault_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.araddr   = addr_q;
    assign bus.arvalid  = arvalid_q;
    assign bus.rready   = rready_q;
    assign bus.awaddr   = addr_q;
    assign bus.awvalid  = awvalid_q;
    assign bus.wdata    = wdata_q;
    assign bus.wstrb    = wstrb_q;
    assign bus.wvalid   = wvalid_q;
    assign bus.bready   = bready_q;
    assign lsu_rdata_o  = rdata_q;
    assign lsu_rvalid_o = rvalid_q;
    assign lsu_wready_o = wready_q;
    assign lsu_fault_o  = fault_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu with a hand-driven AXI4-Lite slave.
module tb_ysyx_lsu;

    logic        clk;
    logic        rst;
    logic        lsu_avalid;
    logic        lsu_ren;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [2:0]  lsu_func3;
    logic [31:0] lsu_rdata_o;
    logic        lsu_rvalid_o;
    logic        lsu_wready_o;
    logic        lsu_fault_o;

    int checks = 0;
    int errors = 0;

    ysyx_lsu_if bus ();

    ysyx_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_avalid   (lsu_avalid),
        .lsu_ren      (lsu_ren),
        .lsu_wen      (lsu_wen),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_func3    (lsu_func3),
        .lsu_rdata_o  (lsu_rdata_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .lsu_wready_o (lsu_wready_o),
        .lsu_fault_o  (lsu_fault_o),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3);
        lsu_avalid = 1'b1;
        lsu_ren    = ren;
        lsu_wen    = wen;
        lsu_addr   = addr;
        lsu_wdata  = wdata;
        lsu_func3  = f3;
    endtask

    task automatic slave(input logic arr, input logic rv, input logic [31:0] rd,
                         input logic awr, input logic wr, input logic bv, input logic [1:0] br);
        bus.arready = arr;
        bus.rvalid  = rv;
        bus.rdata   = rd;
        bus.rresp   = 2'b00;
        bus.awready = awr;
        bus.wready  = wr;
        bus.bvalid  = bv;
        bus.bresp   = br;
    endtask

    initial begin
        rst        = 1'b1;
        lsu_avalid = 1'b0;
        lsu_ren    = 1'b0;
        lsu_wen    = 1'b0;
        lsu_addr   = '0;
        lsu_wdata  = '0;
        lsu_func3  = '0;
        slave(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
        chk("rst_awvalid", 32'(bus.awvalid), 32'd0);
        chk("rst_wvalid",  32'(bus.wvalid),  32'd0);
        chk("rst_rready",  32'(bus.rready),  32'd0);
        chk("rst_bready",  32'(bus.bready),  32'd0);
        chk("rst_rvalid_o", 32'(lsu_rvalid_o), 32'd0);
        chk("rst_wready_o", 32'(lsu_wready_o), 32'd0);
        chk("rst_fault_o",  32'(lsu_fault_o),  32'd0);
        chk("rst_rdata_o",  lsu_rdata_o,       32'h0);

        // LW aligned, zero-wait bus
        slave(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 2'b00);
        req(1'b1, 1'b0, 32'h8000_0004, 32'h0, 3'b010);
        tick();
        chk("lw_t1_arvalid", 32'(bus.arvalid), 32'd1);
        chk("lw_t1_araddr",  bus.araddr,       32'h8000_0004);
        chk("lw_t1_rvalid_o", 32'(lsu_rvalid_o), 32'd0);
        tick();
        chk("lw_t2_arvalid", 32'(bus.arvalid), 32'd0);
        chk("lw_t2_rready",  32'(bus.rready),  32'd1);
        tick();
        chk("lw_t3_rvalid_o", 32'(lsu_rvalid_o), 32'd1);
        chk("lw_t3_rdata_o",  lsu_rdata_o,       32'hDEAD_BEEF);
        chk("lw_t3_fault_o",  32'(lsu_fault_o),  32'd0);
        chk("lw_t3_rready",   32'(bus.rready),   32'd0);
        lsu_avalid = 1'b0;
        tick();
        chk("lw_t4_rvalid_o", 32'(lsu_rvalid_o), 32'd0);
        chk("lw_t4_rdata_hold", lsu_rdata_o,     32'hDEAD_BEEF);

        // LB at byte 3, sign extended
        slave(1'b1, 1'b1, 32'h80FF_FFFF, 1'b0, 1'b0, 1'b0, 2'b00);
        req(1'b1, 1'b0, 32'h8000_0003, 32'h0, 3'b000);
        tick(); tick(); tick();
        chk("lb_rvalid_o", 32'(lsu_rvalid_o), 32'd1);
        chk("lb_rdata_o",  lsu_rdata_o,       32'hFFFF_FF80);
        lsu_avalid = 1'b0;
        tick();

        // LBU at byte 3, zero extended
        req(1'b1, 1'b0, 32'h8000_0003, 32'h0, 3'b100);
        tick(); tick(); tick();
        chk("lbu_rvalid_o", 32'(lsu_rvalid_o), 32'd1);
        chk("lbu_rdata_o",  lsu_rdata_o,       32'h0000_0080);
        lsu_avalid = 1'b0;
        tick();

        // SH at halfword 1, zero-wait bus
        slave(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'b00);
        req(1'b0, 1'b1, 32'h8000_0002, 32'h0000_1234, 3'b001);
        tick();
        chk("sh_t1_awvalid", 32'(bus.awvalid), 32'd1);
        chk("sh_t1_wvalid",  32'(bus.wvalid),  32'd1);
        chk("sh_t1_awaddr",  bus.awaddr,       32'h8000_0002);
        chk("sh_t1_wdata",   bus.wdata,        32'h1234_0000);
        chk("sh_t1_wstrb",   32'(bus.wstrb),   32'hC);
        tick();
        chk("sh_t2_bready",  32'(bus.bready),  32'd1);
        chk("sh_t2_awvalid", 32'(bus.awvalid), 32'd0);
        chk("sh_t2_wvalid",  32'(bus.wvalid),  32'd0);
        tick();
        chk("sh_t3_wready_o", 32'(lsu_wready_o), 32'd1);
        chk("sh_t3_rvalid_o", 32'(lsu_rvalid_o), 32'd0);
        chk("sh_t3_fault_o",  32'(lsu_fault_o),  32'd0);
        lsu_avalid = 1'b0;
        tick();
        chk("sh_t4_wready_o", 32'(lsu_wready_o), 32'd0);

        // SW with AW accepted three cycles after W
        slave(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00);
        req(1'b0, 1'b1, 32'h8000_0008, 32'hA5A5_A5A5, 3'b010);
        tick();
        chk("sw_t1_both_valid", 32'({bus.awvalid, bus.wvalid}), 32'd3);
        chk("sw_t1_wstrb",      32'(bus.wstrb), 32'hF);
        chk("sw_t1_wdata",      bus.wdata,      32'hA5A5_A5A5);
        tick();
        chk("sw_t2_wvalid",  32'(bus.wvalid),  32'd0);
        chk("sw_t2_awvalid", 32'(bus.awvalid), 32'd1);
        chk("sw_t2_bready",  32'(bus.bready),  32'd0);
        tick();
        chk("sw_t3_awvalid", 32'(bus.awvalid), 32'd1);
        chk("sw_t3_wready_o", 32'(lsu_wready_o), 32'd0);
        tick();
        chk("sw_t4_awvalid", 32'(bus.awvalid), 32'd1);
        bus.awready = 1'b1;
        tick();
        chk("sw_t5_awvalid", 32'(bus.awvalid), 32'd0);
        chk("sw_t5_bready",  32'(bus.bready),  32'd1);
        chk("sw_t5_wready_o", 32'(lsu_wready_o), 32'd0);
        bus.bvalid = 1'b1;
        tick();
        chk("sw_t6_wready_o", 32'(lsu_wready_o), 32'd1);
        chk("sw_t6_bready",   32'(bus.bready),   32'd0);
        lsu_avalid = 1'b0;
        bus.bvalid = 1'b0;
        tick();

        // misaligned LW: immediate fault, no bus traffic, rdata_o untouched
        slave(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        req(1'b1, 1'b0, 32'h8000_0001, 32'h0, 3'b010);
        tick();
        chk("mis_t1_rvalid_o", 32'(lsu_rvalid_o), 32'd1);
        chk("mis_t1_fault_o",  32'(lsu_fault_o),  32'd1);
        chk("mis_t1_arvalid",  32'(bus.arvalid),  32'd0);
        chk("mis_t1_rdata_hold", lsu_rdata_o,     32'h0000_0080);
        lsu_avalid = 1'b0;
        tick();
        chk("mis_t2_fault_o",  32'(lsu_fault_o),  32'd0);
        chk("mis_t2_rvalid_o", 32'(lsu_rvalid_o), 32'd0);

        // SB with SLVERR write response
        slave(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'b10);
        req(1'b0, 1'b1, 32'h8000_0001, 32'h0000_00AB, 3'b000);
        tick();
        chk("sb_t1_wdata", bus.wdata,      32'h0000_AB00);
        chk("sb_t1_wstrb", 32'(bus.wstrb), 32'h2);
        tick();
        tick();
        chk("sb_t3_wready_o", 32'(lsu_wready_o), 32'd1);
        chk("sb_t3_fault_o",  32'(lsu_fault_o),  32'd1);
        lsu_avalid = 1'b0;
        tick();

        // reset in RD_D abandons the load
        slave(1'b1, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 2'b00);
        req(1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b010);
        tick();
        chk("rr_t1_arvalid", 32'(bus.arvalid), 32'd1);
        tick();
        chk("rr_t2_rready", 32'(bus.rready), 32'd1);
        rst        = 1'b1;
        lsu_avalid = 1'b0;
        bus.rvalid = 1'b1;
        tick();
        chk("rr_valids", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
        chk("rr_rvalid_o", 32'(lsu_rvalid_o), 32'd0);
        chk("rr_rdata_o",  lsu_rdata_o,       32'h0);
        rst = 1'b0;
        tick();
        chk("rr_post_rvalid_o", 32'(lsu_rvalid_o), 32'd0);
        chk("rr_post_rready",   32'(bus.rready),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
